// File: rtl/clk_rate_ctrl_if.sv
// Control and status bundle of the clock-rate controller.
// The board top level drives it through master; the controller uses slave.
interface clk_rate_ctrl_if;
    logic [1:0] sel;
    logic       run;
    logic       step;
    logic       clk_out;
    logic       tick;
    logic [1:0] cur_sel;
    logic       sw_pend;
    logic       stopped;

    modport master (
        output sel, run, step,
        input  clk_out, tick, cur_sel, sw_pend, stopped
    );

    modport slave (
        input  sel, run, step,
        output clk_out, tick, cur_sel, sw_pend, stopped
    );
endinterface

// File: rtl/clk_rate_ctrl.sv
// Divided 50%-duty clock with tick, glitch-free rate switching, and run/pause/single-step.
// Every DIVn must be even and >= 2, and DIVn/2 must fit in CNT_W bits.
module clk_rate_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV0  = 2_500_000,
    parameter int unsigned DIV1  = 2,
    parameter int unsigned DIV2  = 100_000_000,
    parameter int unsigned DIV3  = 10_000_000
) (
    input  logic           CLK,
    input  logic           rst_n,
    clk_rate_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STEP = 2'd2;

    localparam logic [CNT_W-1:0] HALF0 = CNT_W'(DIV0 / 2);
    localparam logic [CNT_W-1:0] HALF1 = CNT_W'(DIV1 / 2);
    localparam logic [CNT_W-1:0] HALF2 = CNT_W'(DIV2 / 2);
    localparam logic [CNT_W-1:0] HALF3 = CNT_W'(DIV3 / 2);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_step_q;
    logic [1:0]       r_cur_sel;

    logic [CNT_W-1:0] w_half;
    logic             w_last;
    logic             w_step_edge;

    // The phase length follows the applied rate only, never the requested one.
    always_comb begin
        w_half = HALF0;
        case (r_cur_sel)
            2'd1:    w_half = HALF1;
            2'd2:    w_half = HALF2;
            2'd3:    w_half = HALF3;
            default: w_half = HALF0;
        endcase
    end

    assign w_last      = (r_cnt == w_half - CNT_W'(1));
    assign w_step_edge = bus.step & ~r_step_q;

    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch and aborts any phase.
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_step_q  <= 1'b0;
            r_cur_sel <= 2'd0;
        end else begin
            // NOTE: non-blocking updates keep every branch reading pre-edge state.
            r_step_q <= bus.step;
            r_tick   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cur_sel <= bus.sel;
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                    if (bus.run) begin
                        r_state <= RUN;
                    end else if (w_step_edge) begin
                        r_state   <= STEP;
                        r_clk_out <= 1'b1;
                        r_tick    <= 1'b1;
                    end
                end
                RUN: begin
                    if (!r_clk_out && !bus.run) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_last) begin
                        r_cnt     <= '0;
                        r_clk_out <= ~r_clk_out;
                        if (!r_clk_out) begin
                            r_tick    <= 1'b1;
                            r_cur_sel <= bus.sel;
                        end else if (!bus.run) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STEP: begin
                    // A step period cannot be cut short; only run=1 at its end continues the clock.
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_clk_out) begin
                            r_clk_out <= 1'b0;
                        end else if (bus.run) begin
                            r_state   <= RUN;
                            r_clk_out <= 1'b1;
                            r_tick    <= 1'b1;
                            r_cur_sel <= bus.sel;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_out = r_clk_out;
    assign bus.tick    = r_tick;
    assign bus.cur_sel = r_cur_sel;
    assign bus.sw_pend = (bus.sel != r_cur_sel);
    assign bus.stopped = (r_state == IDLE);

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Bench for clk_rate_ctrl: directed scenarios plus random traffic, checked against
// a phase-countdown reference model of the controller.
module tb_clk_rate_ctrl;

    localparam int D0 = 8;
    localparam int D1 = 2;
    localparam int D2 = 4;
    localparam int D3 = 6;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;

    clk_rate_ctrl_if bus ();

    clk_rate_ctrl #(
        .CNT_W (32),
        .DIV0  (D0),
        .DIV1  (D1),
        .DIV2  (D2),
        .DIV3  (D3)
    ) u_dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int n_ticks = 0;

    typedef enum {M_IDLE, M_RUN, M_STEP} mode_t;
    mode_t      m_mode = M_IDLE;
    logic       m_lvl  = 1'b0;
    logic       m_tick = 1'b0;
    logic       m_stepq = 1'b0;
    logic [1:0] m_cur  = 2'd0;
    int         m_left = 0;

    function automatic int half_of(input logic [1:0] s);
        case (s)
            2'd0:    return D0 / 2;
            2'd1:    return D1 / 2;
            2'd2:    return D2 / 2;
            default: return D3 / 2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Model: m_left is the number of clock edges until the current phase ends.
    task automatic model_edge();
        logic step_rise;
        if (!rst_n) begin
            m_mode  = M_IDLE;
            m_lvl   = 1'b0;
            m_tick  = 1'b0;
            m_stepq = 1'b0;
            m_cur   = 2'd0;
            m_left  = 0;
            return;
        end
        step_rise = bus.step && !m_stepq;
        m_stepq   = bus.step;
        m_tick    = 1'b0;
        case (m_mode)
            M_IDLE: begin
                m_cur = bus.sel;
                if (bus.run) begin
                    m_mode = M_RUN;
                    m_left = half_of(m_cur);
                end else if (step_rise) begin
                    m_mode = M_STEP;
                    m_lvl  = 1'b1;
                    m_tick = 1'b1;
                    m_left = half_of(m_cur);
                end
            end
            M_RUN: begin
                if (!m_lvl && !bus.run) begin
                    m_mode = M_IDLE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (!m_lvl) begin
                            m_lvl  = 1'b1;
                            m_tick = 1'b1;
                            m_cur  = bus.sel;
                        end else begin
                            m_lvl = 1'b0;
                            if (!bus.run) m_mode = M_IDLE;
                        end
                        m_left = half_of(m_cur);
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lvl) begin
                        m_lvl  = 1'b0;
                        m_left = half_of(m_cur);
                    end else if (bus.run) begin
                        m_mode = M_RUN;
                        m_lvl  = 1'b1;
                        m_tick = 1'b1;
                        m_cur  = bus.sel;
                        m_left = half_of(m_cur);
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        cyc++;
        if (bus.tick === 1'b1) n_ticks++;
        check("clk_out", bus.clk_out, m_lvl);
        check("tick",    bus.tick,    m_tick);
        check("cur_sel", bus.cur_sel, m_cur);
        check("sw_pend", bus.sw_pend, bus.sel != m_cur);
        check("stopped", bus.stopped, m_mode == M_IDLE);
    endtask

    // Cycles until clk_out changes; capped so a stuck output still returns.
    task automatic run_phase(output int len);
        logic lv;
        lv  = bus.clk_out;
        len = 0;
        do begin
            cycle();
            len++;
        end while (bus.clk_out === lv && len < 64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int t0;
        int hi;

        bus.run  = 1'b1;
        bus.sel  = 2'd0;
        bus.step = 1'b0;
        rst_n    = 1'b0;

        // Reset held three cycles with run asserted.
        repeat (3) cycle();
        check("rst_clk_out", bus.clk_out, 0);
        check("rst_tick",    bus.tick,    0);
        check("rst_cur_sel", bus.cur_sel, 0);
        check("rst_sw_pend", bus.sw_pend, 0);
        check("rst_stopped", bus.stopped, 1);

        rst_n = 1'b1;
        cycle();
        check("s1_entry_stopped", bus.stopped, 0);
        run_phase(len);
        check("s1_first_rise", len, 4);
        check("s1_first_tick", bus.tick, 1);
        t0 = n_ticks;
        for (int p = 0; p < 4; p++) begin
            run_phase(len);
            check("s1_phase_len", len, 4);
        end
        check("s1_ticks_per_period", n_ticks - t0, 2);

        // Full-speed rate, applied at the next rise.
        bus.sel = 2'd1;
        run_phase(len);
        run_phase(len);
        check("s2_cur_sel", bus.cur_sel, 1);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("s2_clk_out", bus.clk_out, (k % 2) == 0);
            check("s2_tick",    bus.tick,    (k % 2) == 0);
        end

        // Back to sel=0, then request sel=2 one cycle into a high phase.
        bus.sel = 2'd0;
        run_phase(len);
        check("s3_fast_high", len, 1);
        run_phase(len);
        check("s3_fast_low", len, 1);
        check("s3_cur_sel0", bus.cur_sel, 0);
        cycle();
        bus.sel = 2'd2;
        #1;
        check("s3_pend_set", bus.sw_pend, 1);
        run_phase(len);
        check("s3_rest_high", len, 3);
        check("s3_pend_held", bus.sw_pend, 1);
        check("s3_cur_held", bus.cur_sel, 0);
        run_phase(len);
        check("s3_old_low", len, 4);
        check("s3_cur_applied", bus.cur_sel, 2);
        check("s3_pend_clear", bus.sw_pend, 0);
        run_phase(len);
        check("s3_new_high", len, 2);
        run_phase(len);
        check("s3_new_low", len, 2);

        // Pause one cycle into a high phase.
        bus.sel = 2'd0;
        run_phase(len);
        run_phase(len);
        check("s4_cur_sel0", bus.cur_sel, 0);
        cycle();
        bus.run = 1'b0;
        run_phase(len);
        check("s4_high_finish", len, 3);
        check("s4_stopped", bus.stopped, 1);
        t0 = n_ticks;
        repeat (6) cycle();
        check("s4_no_ticks", n_ticks - t0, 0);
        check("s4_still_low", bus.clk_out, 0);
        bus.run = 1'b1;
        cycle();
        check("s4_restart", bus.stopped, 0);
        run_phase(len);
        check("s4_restart_rise", len, 4);

        // Pause, then single step at sel=3 with step held high.
        bus.run = 1'b0;
        run_phase(len);
        check("s5_pause_high", len, 4);
        check("s5_paused", bus.stopped, 1);
        bus.sel = 2'd3;
        cycle();
        check("s5_idle_cur", bus.cur_sel, 3);
        t0 = n_ticks;
        hi = 0;
        bus.step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (bus.clk_out === 1'b1) hi++;
        end
        bus.step = 1'b0;
        check("s5_step_ticks", n_ticks - t0, 1);
        check("s5_step_high", hi, 3);
        check("s5_step_stopped", bus.stopped, 1);
        cycle();
        t0 = n_ticks;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            bus.step = (k != 1);
            cycle();
            if (bus.clk_out === 1'b1) hi++;
        end
        bus.step = 1'b0;
        check("s5_reedge_ticks", n_ticks - t0, 1);
        check("s5_reedge_high", hi, 3);
        check("s5_reedge_stopped", bus.stopped, 1);

        // Reset for one cycle in the middle of a running high phase.
        bus.sel = 2'd0;
        bus.run = 1'b1;
        run_phase(len);
        check("s6_pre_rise", len, 5);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("s6_rst_clk_out", bus.clk_out, 0);
        check("s6_rst_cur_sel", bus.cur_sel, 0);
        check("s6_rst_stopped", bus.stopped, 1);
        check("s6_rst_tick", bus.tick, 0);
        rst_n = 1'b1;
        cycle();
        check("s6_entry_stopped", bus.stopped, 0);
        run_phase(len);
        check("s6_first_rise", len, 4);
        check("s6_first_tick", bus.tick, 1);
        run_phase(len);
        check("s6_high", len, 4);
        run_phase(len);
        check("s6_low", len, 4);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 5) == 0) bus.sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.step = ~bus.step;
            cycle();
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
